// File: rtl/vcu_msg_bridge.sv
// -----------------------------------------------------------------------------
// vcu_msg_bridge
//
// Single-clock mailbox between a producer CPU (p0) and a consumer CPU (p1).
// p0 pushes message words into a small first-word-fall-through FIFO; p1 pops
// them and reads the head word. The producer sees a credit count of free
// slots, and both sides see status flags and sticky overflow/underflow errors.
//
// Parameters
//   WIDTH      message word width (fixed at 32 in this revision)
//   DEPTH      number of message slots, power of two in 2..8
//   PROG_FULL  occupancy at or above which fifo_prog_full asserts, 1..DEPTH
//
// Ports
//   clk                    in   1      rising-edge clock
//   reset_p                in   1      asynchronous active-high reset
//   p0_vcu_reg_control     in   32     producer select, bits [3:0]
//   p0_vcu_reg_wdata       in   WIDTH  producer write data
//   p0_vcu_reg_wdata_we    in   1      producer write strobe
//   p0_vcu_reg_rdata       out  WIDTH  producer read data (combinational)
//   p1_vcu_reg_control     in   32     consumer select, bits [3:0]
//   p1_vcu_reg_control_we  in   1      consumer control-write strobe
//   p1_vcu_reg_rdata       out  WIDTH  consumer read data (combinational)
//   credit_counter         out  4      free-slot credits
//   is_write_enable        out  1      credit_counter != 0
//   fifo_empty             out  1      occupancy == 0
//   fifo_prog_full         out  1      occupancy >= PROG_FULL
//   fifo_full              out  1      occupancy == DEPTH
//   err_flags              out  2      sticky errors: [0] overflow, [1] underflow
//
// Producer selects: 8 push (write), 7 error clear (write) / error read,
//                   4 write-enable read.
// Consumer selects: 5 pop (control write), 3 not-empty read, 9 head word read,
//                   6 occupancy read.
// -----------------------------------------------------------------------------
module vcu_msg_bridge #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int PROG_FULL = 4
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [31:0]      p0_vcu_reg_control,
  input  logic [WIDTH-1:0] p0_vcu_reg_wdata,
  input  logic             p0_vcu_reg_wdata_we,
  output logic [WIDTH-1:0] p0_vcu_reg_rdata,
  input  logic [31:0]      p1_vcu_reg_control,
  input  logic             p1_vcu_reg_control_we,
  output logic [WIDTH-1:0] p1_vcu_reg_rdata,
  output logic [3:0]       credit_counter,
  output logic             is_write_enable,
  output logic             fifo_empty,
  output logic             fifo_prog_full,
  output logic             fifo_full,
  output logic [1:0]       err_flags
);

  localparam int         PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] L_DEPTH = 4'(DEPTH);
  localparam logic [3:0] L_PROG  = 4'(PROG_FULL);

  localparam logic [3:0] SEL_P0_WEN   = 4'd4;
  localparam logic [3:0] SEL_P0_ERR   = 4'd7;
  localparam logic [3:0] SEL_P0_PUSH  = 4'd8;
  localparam logic [3:0] SEL_P1_NEMP  = 4'd3;
  localparam logic [3:0] SEL_P1_POP   = 4'd5;
  localparam logic [3:0] SEL_P1_OCC   = 4'd6;
  localparam logic [3:0] SEL_P1_HEAD  = 4'd9;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [3:0]       r_occ;
  logic [3:0]       r_credit;
  logic [1:0]       r_err;

  logic [3:0]       w_p0_sel;
  logic [3:0]       w_p1_sel;
  logic             w_push_req;
  logic             w_pop_req;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_empty;
  logic [1:0]       w_err_set;
  logic [1:0]       w_err_clr;
  logic             w_unused;

  assign w_p0_sel = p0_vcu_reg_control[3:0];
  assign w_p1_sel = p1_vcu_reg_control[3:0];

  // Only the select nibbles of the control registers are decoded.
  assign w_unused = ^{p0_vcu_reg_control[31:4], p1_vcu_reg_control[31:4]};

  assign w_push_req = p0_vcu_reg_wdata_we   & (w_p0_sel == SEL_P0_PUSH);
  assign w_pop_req  = p1_vcu_reg_control_we & (w_p1_sel == SEL_P1_POP);

  // Acceptance looks only at registered state, so a push while full is
  // dropped even if a pop frees a slot in the same cycle (and vice versa).
  assign w_empty   = (r_occ == 4'd0);
  assign w_push_ok = w_push_req & (r_credit != 4'd0);
  assign w_pop_ok  = w_pop_req  & ~w_empty;

  assign w_err_set = {w_pop_req & w_empty, w_push_req & (r_credit == 4'd0)};
  assign w_err_clr = (p0_vcu_reg_wdata_we && (w_p0_sel == SEL_P0_ERR)) ?
                     p0_vcu_reg_wdata[1:0] : 2'b00;

  // Message storage carries no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= p0_vcu_reg_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop_ok)  r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_occ    <= 4'd0;
      r_credit <= L_DEPTH;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          r_occ    <= r_occ + 4'd1;
          r_credit <= r_credit - 4'd1;
        end
        2'b01: begin
          r_occ    <= r_occ - 4'd1;
          r_credit <= r_credit + 4'd1;
        end
        default: begin
          r_occ    <= r_occ;
          r_credit <= r_credit;
        end
      endcase
    end
  end

  // A set event in the same cycle wins over a clear.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_err <= 2'b00;
    end else begin
      r_err <= (r_err & ~w_err_clr) | w_err_set;
    end
  end

  assign credit_counter  = r_credit;
  assign is_write_enable = (r_credit != 4'd0);
  assign fifo_empty      = w_empty;
  assign fifo_full       = (r_occ == L_DEPTH);
  assign fifo_prog_full  = (r_occ >= L_PROG);
  assign err_flags       = r_err;

  always_comb begin
    p0_vcu_reg_rdata = '0;
    case (w_p0_sel)
      SEL_P0_WEN: p0_vcu_reg_rdata = {{(WIDTH-1){1'b0}}, is_write_enable};
      SEL_P0_ERR: p0_vcu_reg_rdata = {{(WIDTH-2){1'b0}}, r_err};
      default:    p0_vcu_reg_rdata = '0;
    endcase
  end

  always_comb begin
    p1_vcu_reg_rdata = '0;
    case (w_p1_sel)
      SEL_P1_NEMP: p1_vcu_reg_rdata = {{(WIDTH-1){1'b0}}, ~w_empty};
      SEL_P1_HEAD: p1_vcu_reg_rdata = w_empty ? '0 : r_mem[r_head];
      SEL_P1_OCC:  p1_vcu_reg_rdata = {{(WIDTH-4){1'b0}}, r_occ};
      default:     p1_vcu_reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_vcu_msg_bridge.sv
// Testbench for vcu_msg_bridge: directed scenarios plus randomized traffic,
// checked against a queue-based mailbox model.
module tb_vcu_msg_bridge;

  localparam int DEPTH     = 8;
  localparam int PROG_FULL = 4;

  logic        clk;
  logic        reset_p;
  logic [31:0] p0_vcu_reg_control;
  logic [31:0] p0_vcu_reg_wdata;
  logic        p0_vcu_reg_wdata_we;
  logic [31:0] p0_vcu_reg_rdata;
  logic [31:0] p1_vcu_reg_control;
  logic        p1_vcu_reg_control_we;
  logic [31:0] p1_vcu_reg_rdata;
  logic [3:0]  credit_counter;
  logic        is_write_enable;
  logic        fifo_empty;
  logic        fifo_prog_full;
  logic        fifo_full;
  logic [1:0]  err_flags;

  vcu_msg_bridge #(.WIDTH(32), .DEPTH(DEPTH), .PROG_FULL(PROG_FULL)) dut (
    .clk                   (clk),
    .reset_p               (reset_p),
    .p0_vcu_reg_control    (p0_vcu_reg_control),
    .p0_vcu_reg_wdata      (p0_vcu_reg_wdata),
    .p0_vcu_reg_wdata_we   (p0_vcu_reg_wdata_we),
    .p0_vcu_reg_rdata      (p0_vcu_reg_rdata),
    .p1_vcu_reg_control    (p1_vcu_reg_control),
    .p1_vcu_reg_control_we (p1_vcu_reg_control_we),
    .p1_vcu_reg_rdata      (p1_vcu_reg_rdata),
    .credit_counter        (credit_counter),
    .is_write_enable       (is_write_enable),
    .fifo_empty            (fifo_empty),
    .fifo_prog_full        (fifo_prog_full),
    .fifo_full             (fifo_full),
    .err_flags             (err_flags)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_q[$];
  logic [1:0]  m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_err = 2'b00;
  endtask

  // Compare every visible output and read-back register with the model.
  task automatic check_all();
    int occ;
    occ = m_q.size();
    p0_vcu_reg_wdata_we   = 1'b0;
    p1_vcu_reg_control_we = 1'b0;
    chk("credit",    32'(credit_counter),  32'(DEPTH - occ));
    chk("wr_en",     32'(is_write_enable), 32'(occ != DEPTH));
    chk("empty",     32'(fifo_empty),      32'(occ == 0));
    chk("full",      32'(fifo_full),       32'(occ == DEPTH));
    chk("prog_full", 32'(fifo_prog_full),  32'(occ >= PROG_FULL));
    chk("err",       32'(err_flags),       32'(m_err));
    p1_vcu_reg_control = 32'd6;
    #1;
    chk("p1_occ", p1_vcu_reg_rdata, 32'(occ));
    chk("credit_plus_occ", 32'(credit_counter) + p1_vcu_reg_rdata, 32'(DEPTH));
    p1_vcu_reg_control = 32'd9;
    #1;
    chk("p1_head", p1_vcu_reg_rdata, (occ != 0) ? m_q[0] : 32'd0);
    p1_vcu_reg_control = 32'd3;
    #1;
    chk("p1_nempty", p1_vcu_reg_rdata, 32'(occ != 0));
    p1_vcu_reg_control = 32'hABCD_0000 | 32'($urandom_range(0, 2));
    p0_vcu_reg_control = 32'd4;
    #1;
    chk("p1_other", p1_vcu_reg_rdata, 32'd0);
    chk("p0_wen", p0_vcu_reg_rdata, 32'(occ != DEPTH));
    p0_vcu_reg_control = 32'd7;
    #1;
    chk("p0_err", p0_vcu_reg_rdata, 32'(m_err));
    p0_vcu_reg_control = 32'h1234_5000 | 32'($urandom_range(10, 15));
    #1;
    chk("p0_other", p0_vcu_reg_rdata, 32'd0);
  endtask

  // Drive one cycle of strobes, advance the model at the edge, then check.
  task automatic step(input logic [31:0] p0sel, input logic p0we, input logic [31:0] wd,
                      input logic [31:0] p1sel, input logic p1we);
    bit push, pop, was_full, was_empty;
    logic [1:0] clr;
    p0_vcu_reg_control    = p0sel;
    p0_vcu_reg_wdata      = wd;
    p0_vcu_reg_wdata_we   = p0we;
    p1_vcu_reg_control    = p1sel;
    p1_vcu_reg_control_we = p1we;
    @(posedge clk);
    push      = p0we && (p0sel[3:0] == 4'd8);
    pop       = p1we && (p1sel[3:0] == 4'd5);
    clr       = (p0we && (p0sel[3:0] == 4'd7)) ? wd[1:0] : 2'b00;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (pop && !was_empty) void'(m_q.pop_front());
    if (push && !was_full) m_q.push_back(wd);
    m_err = (m_err & ~clr) | {pop && was_empty, push && was_full};
    #1;
    check_all();
  endtask

  task automatic push(input logic [31:0] d);
    step(32'd8, 1'b1, d, 32'd0, 1'b0);
  endtask
  task automatic pop();
    step(32'd0, 1'b0, 32'd0, 32'd5, 1'b1);
  endtask
  task automatic push_pop(input logic [31:0] d);
    step(32'd8, 1'b1, d, 32'd5, 1'b1);
  endtask
  task automatic clr_err(input logic [1:0] m);
    step(32'd7, 1'b1, {30'd0, m}, 32'd0, 1'b0);
  endtask
  task automatic idle();
    step(32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s0, s1;
    int r;
    reset_p               = 1'b1;
    p0_vcu_reg_control    = '0;
    p0_vcu_reg_wdata      = '0;
    p0_vcu_reg_wdata_we   = 1'b0;
    p1_vcu_reg_control    = '0;
    p1_vcu_reg_control_we = 1'b0;
    model_reset();
    #25;
    check_all();
    @(negedge clk);
    reset_p = 1'b0;

    // Three words in, read back in order.
    push(32'hA1); push(32'hA2); push(32'hA3);
    pop(); pop(); pop();

    // Overfill: ninth word dropped, overflow flagged.
    for (int i = 0; i < 9; i++) push(32'hB0 + 32'(i));
    chk("ovf_flag", 32'(err_flags), 32'd1);
    for (int i = 0; i < 8; i++) pop();
    clr_err(2'b11);

    // Underflow, then clear.
    pop();
    chk("udf_flag", 32'(err_flags), 32'd2);
    clr_err(2'b11);

    // Clear of bit 1 coincident with an underflow: set wins.
    step(32'd7, 1'b1, 32'd2, 32'd5, 1'b1);
    clr_err(2'b10);

    // Simultaneous push/pop at occupancy 4, then at full.
    for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i));
    push_pop(32'hC4);
    for (int i = 0; i < 4; i++) push(32'hD0 + 32'(i));
    push_pop(32'hDEAD);
    chk("full_pp_occ", 32'(credit_counter), 32'd1);
    for (int i = 0; i < 7; i++) pop();
    clr_err(2'b01);

    // Push/pop pairs separated by random gaps, wrapping the pointers.
    for (int i = 0; i < 20; i++) begin
      push($urandom());
      repeat ($urandom_range(0, 3)) idle();
      pop();
      repeat ($urandom_range(0, 2)) idle();
    end

    // Random traffic including non-decoded selects and error clears.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      s0 = $urandom() & 32'hFFFF_FFF0;
      if (r < 6)       s0 = s0 | 32'd8;
      else if (r == 6) s0 = s0 | 32'd7;
      else             s0 = s0 | 32'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      s1 = $urandom() & 32'hFFFF_FFF0;
      if (r < 6) s1 = s1 | 32'd5;
      else       s1 = s1 | 32'($urandom_range(0, 15));
      step(s0, 1'($urandom_range(0, 1)), $urandom(), s1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with words queued, strobes ignored during reset.
    while (m_q.size() != 0) pop();
    clr_err(2'b11);
    for (int i = 0; i < 5; i++) push(32'hE0 + 32'(i));
    #3;
    reset_p = 1'b1;
    #1;
    model_reset();
    chk("async_credit", 32'(credit_counter), 32'(DEPTH));
    chk("async_empty",  32'(fifo_empty), 32'd1);
    check_all();
    p0_vcu_reg_control    = 32'd8;
    p0_vcu_reg_wdata      = 32'h77;
    p0_vcu_reg_wdata_we   = 1'b1;
    p1_vcu_reg_control    = 32'd5;
    p1_vcu_reg_control_we = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_p = 1'b0;
    push(32'h55);
    push(32'h66);
    pop();
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vcu_msg_bridge.md
VCU_MSG_BRIDGE -- requirements
Module: vcu_msg_bridge

Interface
REQ-001 Parameter WIDTH, default 32, message word width in bits; fixed at 32 in this revision.
REQ-002 Parameter DEPTH, default 8, message slots; SHALL be a power of two in the range 2..8.
REQ-003 Parameter PROG_FULL, default 4, occupancy threshold for fifo_prog_full; range 1..DEPTH.
REQ-004 clk  in  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 reset_p  in  1  asynchronous, active-high reset.
REQ-006 p0_vcu_reg_control  in  32  producer CPU control register; bits [3:0] select the function.
REQ-007 p0_vcu_reg_wdata  in  32  producer CPU write data.
REQ-008 p0_vcu_reg_wdata_we  in  1  producer write strobe, one cycle wide.
REQ-009 p0_vcu_reg_rdata  out  32  producer read data (combinational).
REQ-010 p1_vcu_reg_control  in  32  consumer CPU control register; bits [3:0] select the function.
REQ-011 p1_vcu_reg_control_we  in  1  consumer control-write strobe, one cycle wide.
REQ-012 p1_vcu_reg_rdata  out  32  consumer read data (combinational).
REQ-013 credit_counter  out  4  free-slot credits.
REQ-014 is_write_enable  out  1  1 when credit_counter != 0.
REQ-015 fifo_empty, fifo_prog_full, fifo_full  out  1 each  status flags.
REQ-016 err_flags  out  2  sticky errors: bit0 = overflow, bit1 = underflow.

Function
REQ-017 Push request = p0_vcu_reg_wdata_we & (p0_vcu_reg_control[3:0] == 8).
REQ-018 Pop request = p1_vcu_reg_control_we & (p1_vcu_reg_control[3:0] == 5).
REQ-019 A push SHALL be accepted only if credit_counter != 0 in that cycle; the word goes to the tail and the tail pointer advances modulo DEPTH.
REQ-020 A pop SHALL be accepted only if fifo_empty == 0 in that cycle; the head pointer advances modulo DEPTH.
REQ-021 Acceptance uses registered state only: a push while full is dropped even with a simultaneous accepted pop; a pop while empty is ignored even with a simultaneous accepted push.
REQ-022 credit_counter SHALL decrement on an accepted push alone, increment on an accepted pop alone, and hold when both or neither are accepted.
REQ-023 Invariant: credit_counter + occupancy == DEPTH at every cycle.
REQ-024 Flags are decoded from registered occupancy: fifo_empty = (occ == 0), fifo_full = (occ == DEPTH), fifo_prog_full = (occ >= PROG_FULL); they update the cycle after the causing strobe.
REQ-025 FIFO is first-word-fall-through: the head word is valid on p1 select 9 one cycle after the push that makes the FIFO non-empty.
REQ-026 p1_vcu_reg_rdata SHALL return: select 3 -> {31'0, ~fifo_empty}; select 9 -> head word (0 when empty); select 6 -> {28'0, occupancy}; any other select -> 0.
REQ-027 p0_vcu_reg_rdata SHALL return: select 4 -> {31'0, is_write_enable}; select 7 -> {30'0, err_flags}; any other select -> 0.
REQ-028 A dropped push SHALL set err_flags[0]; an ignored pop SHALL set err_flags[1]; both remain set until cleared.
REQ-029 p0_vcu_reg_wdata_we with p0 select 7 SHALL clear err flags where wdata[1:0] = 1; a set event in the same cycle wins over the clear.
REQ-030 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering.

Reset
REQ-031 While reset_p = 1, asynchronously: pointers and occupancy = 0, credit_counter = DEPTH, err_flags = 0, fifo_empty = 1, fifo_full = 0, fifo_prog_full = 0, is_write_enable = 1.
REQ-032 Storage contents are not reset; select 9 SHALL read 0 while empty.
REQ-033 Reset asserted mid-transfer SHALL discard all queued words; strobes during reset have no effect.
REQ-034 Deassertion is synchronised externally; the first push is accepted on the first clk edge after reset_p falls.

Verification
REQ-035 Reset, then 3 pushes (0xA1, 0xA2, 0xA3) -> credit_counter 5, select 6 reads 3, select 9 reads 0xA1, pops return 0xA1, 0xA2, 0xA3 in order, then credit_counter 8 and fifo_empty 1.
REQ-036 9 pushes with DEPTH = 8 -> fifo_full 1, credit_counter 0, is_write_enable 0, err_flags 01, 9th word absent, prog_full asserts after the 4th push.
REQ-037 Pop on empty -> err_flags 10, occupancy stays 0; p0 write of 0x3 with select 7 -> err_flags 00.
REQ-038 Simultaneous push and pop at occupancy 4 -> occupancy 4, credit_counter 4 unchanged; same at full -> push dropped, pop accepted, occupancy 7.
REQ-039 20 push/pop pairs interleaved with random gaps -> data order preserved across pointer wrap; credit + occupancy == 8 checked every cycle.
REQ-040 reset_p pulsed between clock edges with 5 words queued -> outputs take reset values immediately, before the next edge.
